// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplies take MULT_CYCLES cycles, divides take one quotient bit per cycle plus a sign-fix cycle.
module mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_we,
  input  logic             i_wsel,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_MAX = (WIDTH > MULT_CYCLES) ? WIDTH : MULT_CYCLES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_div;
  logic               r_signA;
  logic               r_signB;
  logic               r_dz;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_isDiv;
  logic               w_inSigned;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_aExt;
  logic [2*WIDTH-1:0] w_bExt;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo;
  logic [2*WIDTH-1:0] w_mulResult;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH:0]     w_remSub;
  logic               w_qBit;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;

  // Even opcodes are the signed variants in both families.
  assign w_isDiv    = (i_op[2:1] == 2'b01);
  assign w_inSigned = ~i_op[0];
  assign w_absA     = (w_inSigned && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_absB     = (w_inSigned && i_b[WIDTH-1]) ? -i_b : i_b;

  // Extending to 2*WIDTH first keeps the truncated product exact in both signednesses.
  assign w_aExt = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_bExt = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod = w_aExt * w_bExt;
  assign w_hilo = {r_hi, r_lo};

  always_comb begin
    w_mulResult = w_prod;
    case (r_op[2:1])
      2'b10:   w_mulResult = w_hilo + w_prod;
      2'b11:   w_mulResult = w_hilo - w_prod;
      default: w_mulResult = w_prod;
    endcase
  end

  // Restoring step: borrow out of the trial subtract means the divisor did not fit.
  assign w_remShift = {r_rem, r_quot[WIDTH-1]};
  assign w_remSub   = w_remShift - {1'b0, r_div};
  assign w_qBit     = ~w_remSub[WIDTH];
  assign w_remNext  = w_qBit ? w_remSub[WIDTH-1:0] : w_remShift[WIDTH-1:0];

  assign w_quotFix = (r_signA ^ r_signB) ? -r_quot : r_quot;
  assign w_remFix  = r_signA ? -r_rem : r_rem;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_dz    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_flush) begin
            if (i_start) begin
              r_a    <= i_a;
              r_b    <= i_b;
              r_op   <= i_op;
              r_busy <= 1'b1;
              if (w_isDiv) begin
                r_signA <= w_inSigned & i_a[WIDTH-1];
                r_signB <= w_inSigned & i_b[WIDTH-1];
                r_rem   <= '0;
                r_quot  <= w_absA;
                r_div   <= w_absB;
                r_cnt   <= CW'(WIDTH - 1);
                if (i_b == '0) begin
                  r_dz    <= 1'b1;
                  r_state <= FIX;
                end else begin
                  r_dz    <= 1'b0;
                  r_state <= DIV;
                end
              end else begin
                r_dz    <= 1'b0;
                r_cnt   <= CW'(MULT_CYCLES - 1);
                r_state <= MUL;
              end
            end else if (i_we) begin
              if (i_wsel) r_hi <= i_a;
              else        r_lo <= i_a;
            end
          end
        end
        MUL: begin
          if (i_flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_mulResult;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DIV: begin
          if (i_flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem  <= w_remNext;
            r_quot <= {r_quot[WIDTH-2:0], w_qBit};
            if (r_cnt == '0) r_state <= FIX;
            else             r_cnt   <= r_cnt - CW'(1);
          end
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          if (!i_flush) begin
            r_done <= 1'b1;
            if (r_dz) begin
              r_lo <= '1;
              r_hi <= r_a;
            end else begin
              r_lo <= w_quotFix;
              r_hi <= w_remFix;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
